// File: rtl/ram_pkg.sv
// Shared types, limits and the lane-parity helper for the simple dual-port RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    RAM_CLEAR,
    RAM_READY
  } ram_state_e;

  localparam int unsigned MAX_READ_LATENCY = 4;
  localparam int unsigned MIN_READ_LATENCY = 1;

  // Upper bounds for the parity helper's argument and result vectors.
  localparam int unsigned MAX_PARITY_BITS  = 1024;
  localparam int unsigned MAX_PARITY_LANES = 128;

  // Even parity per lane: bit i is the XOR of data[i*lane_w +: lane_w].
  function automatic logic [MAX_PARITY_LANES-1:0] byte_parity(
    input logic [MAX_PARITY_BITS-1:0] data,
    input int unsigned                nbytes,
    input int unsigned                lane_w = 8
  );
    logic [MAX_PARITY_LANES-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < nbytes; i++) begin
      for (int unsigned j = 0; j < lane_w; j++) begin
        p[i] = p[i] ^ data[i*lane_w+j];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-path delay line: STAGES registers of data plus a valid bit each.
// Data registers load only with valid, so the output holds between reads.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_stages
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        valid_q[0] <= in_valid;
        if (in_valid) data_q[0] <= in_data;
        for (int unsigned i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/ram_sdp_pipe.sv
// Simple dual-port RAM: byte-enabled write port, pipelined read port, post-reset clear.
// Define RAM_PARITY_EN for per-lane even parity storage and the parity_err output.
module ram_sdp_pipe
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WRITE_FIRST  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             init_busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid
`ifdef RAM_PARITY_EN
  ,
  output logic                             parity_err
`endif
);

  localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
  localparam int unsigned PAR_W  = NBYTES;
`else
  localparam int unsigned PAR_W  = 0;
`endif
  localparam int unsigned WORD_W = DATA_WIDTH + PAR_W;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
    $error("ram_sdp_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("ram_sdp_pipe: READ_LATENCY must be within 1..4");
  end

  // Parity, when enabled, sits in the top NBYTES bits of each stored word.
  logic [WORD_W-1:0] mem [DEPTH];

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RAM_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RAM_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = RAM_READY;
      end
      RAM_READY: ;
      default:   state_d = RAM_CLEAR;
    endcase
  end

  assign init_busy = (state_q == RAM_CLEAR);

  logic [DATA_WIDTH-1:0] wr_merged;
  logic [WORD_W-1:0]     wr_word, rd_word;
  logic                  rd_acc, wr_hit;

  always_comb begin
    wr_merged = mem[wr_addr][DATA_WIDTH-1:0];
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (wr_be[b]) wr_merged[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

`ifdef RAM_PARITY_EN
  assign wr_word = {NBYTES'(byte_parity(MAX_PARITY_BITS'(wr_merged), NBYTES, BYTE_WIDTH)),
                    wr_merged};
`else
  assign wr_word = wr_merged;
`endif

  // Write-first forwards the merged word; read-first sees the array before this edge.
  assign wr_hit  = (WRITE_FIRST != 0) && wr_en && (wr_addr == rd_addr);
  assign rd_word = wr_hit ? wr_word : mem[rd_addr];
  assign rd_acc  = rd_en && (state_q == RAM_READY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == RAM_CLEAR) mem[cnt_q] <= '0;
      else if (wr_en)           mem[wr_addr] <= wr_word;
    end
  end

  logic              s1_valid_q;
  logic [WORD_W-1:0] s1_word_q, out_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) s1_word_q <= rd_word;
    end
  end

  ram_rd_pipe #(
    .WIDTH  (WORD_W),
    .STAGES (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid_q),
    .in_data   (s1_word_q),
    .out_valid (rd_valid),
    .out_data  (out_word)
  );

  assign rd_data = out_word[DATA_WIDTH-1:0];

`ifdef RAM_PARITY_EN
  assign parity_err = rd_valid &&
      (NBYTES'(byte_parity(MAX_PARITY_BITS'(out_word[DATA_WIDTH-1:0]), NBYTES, BYTE_WIDTH))
       != out_word[WORD_W-1 -: NBYTES]);
`endif

endmodule
